cam_match_sequencer: RTL and testbench

Parametrised multi-match sequencer for the CAM search path. It accepts one WIDTH-bit match vector per search, registers it, and streams every set bit's index out one per cycle in priority order over a valid/ready handshake. This lets downstream reflex-memory logic visit all matching entries, not only the single highest-priority hit. It sits between the CAM match-line array and the entry read/update logic.

---
 rtl/cam_pkg.sv | 12 +
 rtl/cam_prio_enc.sv | 35 +++
 rtl/cam_match_sequencer.sv | 131 +++++++++++++
 tb/tb_cam_match_sequencer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared CAM definitions: sequencer FSM states and the default CAM depth.
// The CAM array reuses CAM_WIDTH, so the sequencer and the array agree on depth.
package cam_pkg;

  localparam int CAM_WIDTH = 128;

  typedef enum logic [0:0] {
    SEQ_IDLE = 1'b0,
    SEQ_SCAN = 1'b1
  } seq_state_e;

endpackage

// File: rtl/cam_prio_enc.sv
// Combinational priority encoder over a WIDTH-bit vector.
// PRIO_HIGH=1 reports the highest set index, PRIO_HIGH=0 the lowest.
// pos is 0 when no bit is set, and any flags whether a bit is set.
module cam_prio_enc #(
  parameter int WIDTH     = 128,
  parameter int PRIO_HIGH = 1,
  localparam int IDX_W    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] pos,
  output logic             any
);

  // Scan in the direction that lets the winning bit be the last one written.
  always_comb begin
    pos = '0;
    any = 1'b0;
    if (PRIO_HIGH != 0) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (vec[i]) begin
          pos = IDX_W'(i);
          any = 1'b1;
        end
      end
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (vec[i]) begin
          pos = IDX_W'(i);
          any = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cam_match_sequencer.sv
// Multi-match sequencer: registers a CAM match vector and streams the index
// of every set bit, one per cycle, in priority order over valid/ready.
// Optional feature: define MATCH_SEQ_COUNT_EN to add the match_count port,
// which holds the popcount of the last accepted vector.
module cam_match_sequencer
  import cam_pkg::*;
#(
  parameter int WIDTH     = CAM_WIDTH,
  parameter int PRIO_HIGH = 1,
  localparam int IDX_W    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [WIDTH-1:0] match_vec,
  input  logic             match_valid,
  output logic             match_ready,
  output logic [IDX_W-1:0] idx_out,
  output logic             idx_valid,
  input  logic             idx_ready,
  output logic             idx_last,
  output logic             no_match,
  output logic             busy
`ifdef MATCH_SEQ_COUNT_EN
  , output logic [IDX_W:0] match_count
`endif
);

  seq_state_e       state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             no_match_q, no_match_d;
  logic [IDX_W-1:0] enc_pos;
  logic             enc_any;
  logic             one_hot;
  logic [WIDTH-1:0] clr_mask;
  logic             accept;
  logic             xfer;

`ifdef MATCH_SEQ_COUNT_EN
  logic [IDX_W:0]   count_q, count_d;

  function automatic logic [IDX_W:0] popcount(input logic [WIDTH-1:0] v);
    logic [IDX_W:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      c = c + {{IDX_W{1'b0}}, v[i]};
    end
    return c;
  endfunction
`endif

  cam_prio_enc #(
    .WIDTH     (WIDTH),
    .PRIO_HIGH (PRIO_HIGH)
  ) u_enc (
    .vec (pending_q),
    .pos (enc_pos),
    .any (enc_any)
  );

  // Exactly one pending bit left: clearing the lowest set bit leaves zero.
  assign one_hot  = enc_any && ((pending_q & (pending_q - WIDTH'(1))) == '0);
  assign clr_mask = WIDTH'(1) << enc_pos;
  assign accept   = match_valid && match_ready;
  assign xfer     = idx_valid && idx_ready;
  assign idx_out  = enc_pos;
  assign no_match = no_match_q;
`ifdef MATCH_SEQ_COUNT_EN
  assign match_count = count_q;
`endif

  // State and pending-vector registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= SEQ_IDLE;
      pending_q  <= '0;
      no_match_q <= 1'b0;
`ifdef MATCH_SEQ_COUNT_EN
      count_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      no_match_q <= no_match_d;
`ifdef MATCH_SEQ_COUNT_EN
      count_q    <= count_d;
`endif
    end
  end

  // Next state: flush wins; a new vector overrides the drain of the last index.
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    no_match_d = 1'b0;
`ifdef MATCH_SEQ_COUNT_EN
    count_d    = count_q;
`endif
    if (flush) begin
      state_d   = SEQ_IDLE;
      pending_d = '0;
`ifdef MATCH_SEQ_COUNT_EN
      count_d   = '0;
`endif
    end else begin
      if (xfer) begin
        pending_d = pending_q & ~clr_mask;
        if (idx_last) begin
          state_d = SEQ_IDLE;
        end
      end
      if (accept) begin
        pending_d  = match_vec;
        state_d    = (|match_vec) ? SEQ_SCAN : SEQ_IDLE;
        no_match_d = ~|match_vec;
`ifdef MATCH_SEQ_COUNT_EN
        count_d    = popcount(match_vec);
`endif
      end
    end
  end

  // Outputs: ready in IDLE or while the final index hands off, never in reset/flush.
  always_comb begin
    busy        = (state_q == SEQ_SCAN);
    idx_valid   = busy;
    idx_last    = busy && one_hot;
    match_ready = rst_n && !flush && (!busy || (idx_ready && idx_last));
  end

endmodule

// File: tb/tb_cam_match_sequencer.sv
// Bench for cam_match_sequencer: a high- and a low-priority instance share the
// same stimulus and are compared against queue-based expected index lists.
module tb_cam_match_sequencer;
  import cam_pkg::*;

  localparam int W  = 128;
  localparam int IW = $clog2(W);

  logic          clk = 1'b0;
  logic          rst_n, flush, match_valid, idx_ready;
  logic [W-1:0]  match_vec;

  logic          mr_h, iv_h, il_h, nm_h, bz_h;
  logic [IW-1:0] io_h;
  logic          mr_l, iv_l, il_l, nm_l, bz_l;
  logic [IW-1:0] io_l;
`ifdef MATCH_SEQ_COUNT_EN
  logic [IW:0]   mc_h, mc_l;
`endif

  int checks = 0;
  int errors = 0;
  int q_hi[$];
  int q_lo[$];
  bit exp_nm = 1'b0;
  int exp_cnt = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  cam_match_sequencer #(.WIDTH(W), .PRIO_HIGH(1)) dut_hi (
    .clk(clk), .rst_n(rst_n), .flush(flush), .match_vec(match_vec),
    .match_valid(match_valid), .match_ready(mr_h), .idx_out(io_h),
    .idx_valid(iv_h), .idx_ready(idx_ready), .idx_last(il_h),
    .no_match(nm_h), .busy(bz_h)
`ifdef MATCH_SEQ_COUNT_EN
    , .match_count(mc_h)
`endif
  );

  cam_match_sequencer #(.WIDTH(W), .PRIO_HIGH(0)) dut_lo (
    .clk(clk), .rst_n(rst_n), .flush(flush), .match_vec(match_vec),
    .match_valid(match_valid), .match_ready(mr_l), .idx_out(io_l),
    .idx_valid(iv_l), .idx_ready(idx_ready), .idx_last(il_l),
    .no_match(nm_l), .busy(bz_l)
`ifdef MATCH_SEQ_COUNT_EN
    , .match_count(mc_l)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic cycle(input logic r, input logic f, input logic mv,
                       input logic [W-1:0] v, input logic rdy);
    bit vld, lst, mr, acc;
    int pc;
    rst_n = r; flush = f; match_valid = mv; match_vec = v; idx_ready = rdy;
    #1;
    vld = (q_hi.size() > 0);
    lst = (q_hi.size() == 1);
    mr  = r && !f && (!vld || (rdy && lst));
    if (chk_en) begin
      chk("match_ready_hi", 32'(mr_h), 32'(mr));
      chk("match_ready_lo", 32'(mr_l), 32'(mr));
      chk("idx_valid_hi",   32'(iv_h), 32'(vld));
      chk("idx_valid_lo",   32'(iv_l), 32'(vld));
      chk("busy_hi",        32'(bz_h), 32'(vld));
      chk("idx_last_hi",    32'(il_h), 32'(lst));
      chk("idx_last_lo",    32'(il_l), 32'(lst));
      chk("idx_out_hi",     32'(io_h), vld ? q_hi[0] : 0);
      chk("idx_out_lo",     32'(io_l), vld ? q_lo[0] : 0);
      chk("no_match_hi",    32'(nm_h), 32'(exp_nm));
      chk("no_match_lo",    32'(nm_l), 32'(exp_nm));
`ifdef MATCH_SEQ_COUNT_EN
      chk("match_count_hi", 32'(mc_h), exp_cnt);
      chk("match_count_lo", 32'(mc_l), exp_cnt);
`endif
    end
    @(posedge clk);
    if (!r || f) begin
      q_hi.delete(); q_lo.delete();
      exp_nm = 1'b0; exp_cnt = 0;
    end else begin
      acc = mv && mr;
      exp_nm = 1'b0;
      if (vld && rdy) begin
        void'(q_hi.pop_front());
        void'(q_lo.pop_front());
      end
      if (acc) begin
        q_hi.delete(); q_lo.delete();
        pc = 0;
        for (int i = 0; i < W; i++) begin
          if (v[i]) begin
            q_lo.push_back(i);
            q_hi.push_front(i);
            pc++;
          end
        end
        exp_nm  = (pc == 0);
        exp_cnt = pc;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] v;
    logic [W-1:0] z;
    z = '0;
    rst_n = 1'b0; flush = 1'b0; match_valid = 1'b0; match_vec = '0; idx_ready = 1'b0;
    @(negedge clk);

    // Reset: first cycle unchecked (registers unknown), then all outputs zero.
    cycle(1'b0, 1'b0, 1'b0, z, 1'b0);
    chk_en = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, z, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, z, 1'b0);

    // Vector {127,64,0} drained with idx_ready held high.
    v = '0; v[127] = 1'b1; v[64] = 1'b1; v[0] = 1'b1;
    cycle(1'b1, 1'b0, 1'b1, v, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, z, 1'b1);

    // Same vector with idx_ready toggling: each index must hold while stalled.
    cycle(1'b1, 1'b0, 1'b1, v, 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 1'b0, z, (i % 2) == 0);

    // All-zero vector: one-cycle no_match, no valid indices.
    cycle(1'b1, 1'b0, 1'b1, z, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, z, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, z, 1'b1);

    // {9} then {5} offered during the final transfer of {9}: no bubble.
    v = '0; v[9] = 1'b1;
    cycle(1'b1, 1'b0, 1'b1, v, 1'b1);
    v = '0; v[5] = 1'b1;
    cycle(1'b1, 1'b0, 1'b1, v, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, z, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, z, 1'b1);

    // Flush after the first of three indices, with a competing match_valid.
    v = '0; v[100] = 1'b1; v[50] = 1'b1; v[3] = 1'b1;
    cycle(1'b1, 1'b0, 1'b1, v, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, z, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, v, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, z, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, z, 1'b1);

    // Same scenario with reset instead of flush.
    cycle(1'b1, 1'b0, 1'b1, v, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, z, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, v, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, z, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, z, 1'b1);

    // All entries hit: the widest count and a 128-deep drain.
    v = '1;
    cycle(1'b1, 1'b0, 1'b1, v, 1'b1);
    for (int i = 0; i < 129; i++) cycle(1'b1, 1'b0, 1'b0, z, 1'b1);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      logic r, f, mv, rdy;
      int mode;
      r    = ($urandom_range(0, 63) != 0);
      f    = ($urandom_range(0, 15) == 0);
      mv   = ($urandom_range(0, 1) == 1);
      rdy  = ($urandom_range(0, 3) != 0);
      mode = $urandom_range(0, 7);
      v = '0;
      if (mode != 0) begin
        for (int b = 0; b < W; b++) v[b] = ($urandom_range(0, 31) == 0);
      end
      cycle(r, f, mv, v, rdy);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
